// File: rtl/run_control.sv
// Run controller: holds the processor in reset, lets it run until HALT or the
// watchdog limit, then reports DONE or TIMEOUT until RESTART or reset.
module run_control #(
    parameter int RESET_CYCLES     = 10,
    parameter int POST_HALT_CYCLES = 5,
    parameter int TIMEOUT_CYCLES   = 1000000,
    parameter int COUNT_WIDTH      = 32
) (
    input  logic                   CLK,
    input  logic                   RST_bar,
    input  logic                   RESTART,
    input  logic                   HALT,
    output logic                   CPU_RST_bar,
    output logic                   RUNNING,
    output logic                   DONE,
    output logic                   TIMEOUT,
    output logic [COUNT_WIDTH-1:0] CYCLES
);

    localparam int HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int DRAIN_W = (POST_HALT_CYCLES > 1) ? $clog2(POST_HALT_CYCLES) : 1;

    localparam logic [HOLD_W-1:0]      HOLD_LAST     = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [DRAIN_W-1:0]     DRAIN_LAST    = DRAIN_W'(POST_HALT_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] CYCLES_MAX    = {COUNT_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_RUN      = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_FINISHED = 3'd3,
        ST_EXPIRED  = 3'd4
    } state_e;

    state_e                   state_q,       state_d;
    logic [HOLD_W-1:0]        hold_cnt_q,    hold_cnt_d;
    logic [DRAIN_W-1:0]       drain_cnt_q,   drain_cnt_d;
    logic [COUNT_WIDTH-1:0]   cycles_q,      cycles_d;
    logic                     halt_q,        halt_d;
    logic                     cpu_rst_bar_q, cpu_rst_bar_d;
    logic                     running_q,     running_d;
    logic                     done_q,        done_d;
    logic                     timeout_q,     timeout_d;
    logic                     halt_rise_s;

    assign halt_rise_s = HALT & ~halt_q;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        drain_cnt_d = drain_cnt_q;
        cycles_d    = cycles_q;

        if (RESTART) begin
            state_d     = ST_HOLD;
            hold_cnt_d  = '0;
            drain_cnt_d = '0;
            cycles_d    = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = ST_RUN;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    // A halt rise wins over the watchdog on the same edge.
                    if (halt_rise_s) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = '0;
                    end else if (cycles_q == TIMEOUT_LIMIT) begin
                        state_d = ST_EXPIRED;
                    end else if (cycles_q != CYCLES_MAX) begin
                        cycles_d = cycles_q + 1'b1;
                    end else begin
                        cycles_d = cycles_q;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d     = ST_FINISHED;
                        drain_cnt_d = '0;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 1'b1;
                    end
                end
                ST_FINISHED: begin
                    state_d = ST_FINISHED;
                end
                ST_EXPIRED: begin
                    state_d = ST_EXPIRED;
                end
                default: begin
                    state_d     = ST_HOLD;
                    hold_cnt_d  = '0;
                    drain_cnt_d = '0;
                    cycles_d    = '0;
                end
            endcase
        end

        // The previous-HALT sample is held at zero through HOLD so that a HALT
        // already high when RUN starts is seen as a rise.
        if (RESTART || (state_q == ST_HOLD)) begin
            halt_d = 1'b0;
        end else begin
            halt_d = HALT;
        end

        cpu_rst_bar_d = (state_d == ST_RUN) || (state_d == ST_DRAIN) ||
                        (state_d == ST_FINISHED);
        running_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d        = (state_d == ST_FINISHED);
        timeout_d     = (state_d == ST_EXPIRED);
    end

    // State machine, counters and output registers.
    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            state_q       <= ST_HOLD;
            hold_cnt_q    <= '0;
            drain_cnt_q   <= '0;
            cycles_q      <= '0;
            halt_q        <= 1'b0;
            cpu_rst_bar_q <= 1'b0;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            cycles_q      <= cycles_d;
            halt_q        <= halt_d;
            cpu_rst_bar_q <= cpu_rst_bar_d;
            running_q     <= running_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
        end
    end

    assign CPU_RST_bar = cpu_rst_bar_q;
    assign RUNNING     = running_q;
    assign DONE        = done_q;
    assign TIMEOUT     = timeout_q;
    assign CYCLES      = cycles_q;

endmodule

// File: tb/tb_run_control.sv
// Directed bench for run_control: an edge-level behavioural model is compared
// every cycle, plus literal expectations at the scenario milestones.
module tb_run_control;

    localparam int RC = 10;
    localparam int PH = 5;
    localparam int TO = 50;

    logic        CLK;
    logic        RST_bar;
    logic        RESTART;
    logic        HALT;
    logic        CPU_RST_bar;
    logic        RUNNING;
    logic        DONE;
    logic        TIMEOUT;
    logic [31:0] CYCLES;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    run_control #(
        .RESET_CYCLES    (RC),
        .POST_HALT_CYCLES(PH),
        .TIMEOUT_CYCLES  (TO),
        .COUNT_WIDTH     (32)
    ) dut (
        .CLK        (CLK),
        .RST_bar    (RST_bar),
        .RESTART    (RESTART),
        .HALT       (HALT),
        .CPU_RST_bar(CPU_RST_bar),
        .RUNNING    (RUNNING),
        .DONE       (DONE),
        .TIMEOUT    (TIMEOUT),
        .CYCLES     (CYCLES)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Phase of the program: 0 held in reset, 1 running, 2 draining,
    // 3 finished, 4 watchdog expired. Counters count down remaining edges.
    int          m_phase      = 0;
    int          m_hold_left  = RC;
    int          m_drain_left = 0;
    logic [31:0] m_cycles     = 32'd0;
    logic        m_prev_halt  = 1'b0;

    // Behavioural model, one step per rising edge.
    always @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar || RESTART) begin
            m_phase      <= 0;
            m_hold_left  <= RC;
            m_drain_left <= 0;
            m_cycles     <= 32'd0;
            m_prev_halt  <= 1'b0;
        end else begin
            m_prev_halt <= (m_phase != 0) ? HALT : 1'b0;
            case (m_phase)
                0: begin
                    if (m_hold_left <= 1) m_phase <= 1;
                    else m_hold_left <= m_hold_left - 1;
                end
                1: begin
                    if (HALT && !m_prev_halt) begin
                        m_phase      <= 2;
                        m_drain_left <= PH;
                    end else if (m_cycles == 32'(TO)) begin
                        m_phase <= 4;
                    end else if (m_cycles != 32'hFFFF_FFFF) begin
                        m_cycles <= m_cycles + 32'd1;
                    end
                end
                2: begin
                    if (m_drain_left <= 1) m_phase <= 3;
                    else m_drain_left <= m_drain_left - 1;
                end
                default: ;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        if (check_en) begin
            check("model_cpu_rst_bar", 32'(CPU_RST_bar), 32'(m_phase >= 1 && m_phase <= 3));
            check("model_running",     32'(RUNNING),     32'(m_phase == 1 || m_phase == 2));
            check("model_done",        32'(DONE),        32'(m_phase == 3));
            check("model_timeout",     32'(TIMEOUT),     32'(m_phase == 4));
            check("model_cycles",      CYCLES,           m_cycles);
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic expect_hold(input string name);
        int n;
        n = 0;
        while (!CPU_RST_bar && n < 40) begin
            tick();
            n = n + 1;
        end
        check(name, 32'(n), 32'd10);
        check({name, "_running"}, 32'(RUNNING), 32'd1);
    endtask

    task automatic pulse_restart();
        RESTART = 1'b1;
        tick();
        RESTART = 1'b0;
    endtask

    task automatic expect_drain(input string name, input int already);
        int k;
        k = already;
        while (!DONE && k < 40) begin
            tick();
            k = k + 1;
        end
        check(name, 32'(k), 32'd5);
        check({name, "_running"}, 32'(RUNNING), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_bar = 1'b1;
        RESTART = 1'b0;
        HALT    = 1'b0;
        #2 RST_bar = 1'b0;
        tick();
        tick();
        check("rst_cpu_rst_bar", 32'(CPU_RST_bar), 32'd0);
        check("rst_running",     32'(RUNNING),     32'd0);
        check("rst_done",        32'(DONE),        32'd0);
        check("rst_timeout",     32'(TIMEOUT),     32'd0);
        check("rst_cycles",      CYCLES,           32'd0);
        check_en = 1'b1;

        // Reset release and nominal run, with HALT toggling during drain.
        RST_bar = 1'b1;
        expect_hold("hold_after_reset");
        repeat (20) tick();
        check("nom_cycles_before_halt", CYCLES, 32'd20);
        HALT = 1'b1;
        tick();
        check("nom_drain_running", 32'(RUNNING), 32'd1);
        check("nom_cycles_frozen", CYCLES, 32'd20);
        HALT = 1'b0;
        tick();
        HALT = 1'b1;
        tick();
        expect_drain("nom_drain_len", 2);
        check("nom_done",    32'(DONE),    32'd1);
        check("nom_timeout", 32'(TIMEOUT), 32'd0);
        check("nom_cycles",  CYCLES,       32'd20);
        repeat (3) tick();
        check("finished_sticky", 32'(DONE), 32'd1);

        // Restart from FINISHED with HALT held high: immediate halt.
        pulse_restart();
        check("restart_fin_cpu",    32'(CPU_RST_bar), 32'd0);
        check("restart_fin_done",   32'(DONE),        32'd0);
        check("restart_fin_cycles", CYCLES,           32'd0);
        expect_hold("hold_after_restart_fin");
        tick();
        check("imm_drain_running", 32'(RUNNING), 32'd1);
        check("imm_cycles",        CYCLES,       32'd0);
        expect_drain("imm_drain_len", 0);
        check("imm_done_cycles", CYCLES, 32'd0);

        // Abort mid-RUN.
        HALT = 1'b0;
        pulse_restart();
        expect_hold("hold_before_abort");
        repeat (7) tick();
        check("abort_cycles_before", CYCLES, 32'd7);
        pulse_restart();
        check("abort_cpu",     32'(CPU_RST_bar), 32'd0);
        check("abort_running", 32'(RUNNING),     32'd0);
        check("abort_cycles",  CYCLES,           32'd0);
        expect_hold("hold_after_abort");

        // Watchdog expiry with HALT low.
        begin
            int k;
            k = 0;
            while (!TIMEOUT && k < 100) begin
                tick();
                k = k + 1;
            end
            check("to_edges", 32'(k), 32'd51);
        end
        check("to_cpu",     32'(CPU_RST_bar), 32'd0);
        check("to_cycles",  CYCLES,           32'd50);
        check("to_done",    32'(DONE),        32'd0);
        check("to_running", 32'(RUNNING),     32'd0);
        repeat (3) tick();
        check("to_sticky", 32'(TIMEOUT), 32'd1);

        // HALT rise on the same edge as the timeout condition.
        pulse_restart();
        check("restart_to_timeout", 32'(TIMEOUT), 32'd0);
        expect_hold("hold_before_tie");
        repeat (50) tick();
        check("tie_cycles_at_limit", CYCLES, 32'd50);
        HALT = 1'b1;
        tick();
        check("tie_timeout",  32'(TIMEOUT), 32'd0);
        check("tie_running",  32'(RUNNING), 32'd1);
        check("tie_cycles",   CYCLES,       32'd50);
        expect_drain("tie_drain_len", 0);
        check("tie_done",         32'(DONE),    32'd1);
        check("tie_timeout_done", 32'(TIMEOUT), 32'd0);

        // Reset asserted mid-DRAIN acts without a clock edge.
        HALT = 1'b0;
        pulse_restart();
        expect_hold("hold_before_drain_rst");
        repeat (10) tick();
        HALT = 1'b1;
        tick();
        tick();
        tick();
        check("drain_rst_pre_running", 32'(RUNNING), 32'd1);
        RST_bar = 1'b0;
        #1;
        check("drain_rst_cpu",     32'(CPU_RST_bar), 32'd0);
        check("drain_rst_running", 32'(RUNNING),     32'd0);
        check("drain_rst_cycles",  CYCLES,           32'd0);
        HALT = 1'b0;
        tick();
        RST_bar = 1'b1;
        expect_hold("hold_after_drain_rst");

        // RESTART during HOLD restarts the hold count.
        pulse_restart();
        repeat (4) tick();
        check("hold_restart_mid_cpu", 32'(CPU_RST_bar), 32'd0);
        pulse_restart();
        expect_hold("hold_after_hold_restart");
        repeat (3) tick();
        check("final_cycles", CYCLES, 32'd3);
        check_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/run_control.md
RUN_CONTROL -- requirements
Module: run_control

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 10, number of clock cycles the processor reset is held.
REQ-002 SHALL have parameter POST_HALT_CYCLES, default 5, number of cycles between the HALT rise and DONE assertion.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, run-cycle limit before TIMEOUT is declared.
REQ-004 SHALL have parameter COUNT_WIDTH, default 32, width of the cycle counter.
REQ-005 SHALL have port CLK  input  1  processor clock; all state changes on the rising edge.
REQ-006 SHALL have port RST_bar  input  1  reset; asynchronous and active-low.
REQ-007 SHALL have port RESTART  input  1  synchronous one-cycle request to rerun the program.
REQ-008 SHALL have port HALT  input  1  halt line from the processor, synchronous to CLK.
REQ-009 SHALL have port CPU_RST_bar  output  1  registered active-low reset driven to the processor.
REQ-010 SHALL have port RUNNING  output  1  high while in RUN or DRAIN.
REQ-011 SHALL have port DONE  output  1  sticky program-halted flag.
REQ-012 SHALL have port TIMEOUT  output  1  sticky watchdog-expired flag.
REQ-013 SHALL have port CYCLES  output  COUNT_WIDTH  number of RUN cycles counted.

Function
REQ-014 SHALL implement the states HOLD, RUN, DRAIN, FINISHED and EXPIRED in a single registered state machine.
REQ-015 SHALL, in HOLD, increment a hold counter each cycle and move to RUN on the edge where the counter equals RESET_CYCLES-1.
REQ-016 SHALL drive CPU_RST_bar low in HOLD and EXPIRED and high in RUN, DRAIN and FINISHED, registered so that it changes on the state-change edge.
REQ-017 SHALL keep CPU_RST_bar low for exactly RESET_CYCLES rising edges after RST_bar deasserts.
REQ-018 SHALL detect a HALT rise as HALT==1 while the registered previous sample halt_q==0.
REQ-019 SHALL force halt_q to 0 in HOLD, so that HALT already high on RUN entry counts as a rise.
REQ-020 SHALL, in RUN, increment CYCLES on every edge without a HALT rise, saturating at all-ones.
REQ-021 SHALL, in RUN, move to DRAIN on a HALT rise and leave CYCLES unchanged on that edge.
REQ-022 SHALL, in RUN, move to EXPIRED when CYCLES==TIMEOUT_CYCLES and no HALT rise occurs on that edge.
REQ-023 SHALL give a HALT rise priority over timeout when both occur on the same edge.
REQ-024 SHALL, in DRAIN, count POST_HALT_CYCLES edges with CYCLES frozen, then move to FINISHED.
REQ-025 SHALL ignore HALT falls and further rises in DRAIN.
REQ-026 SHALL set DONE=1 in FINISHED and TIMEOUT=1 in EXPIRED; both SHALL be registered and mutually exclusive.
REQ-027 SHALL hold FINISHED and EXPIRED until RESTART or reset.
REQ-028 SHALL, on a RESTART sample in any state, go to HOLD next edge, clearing CYCLES, DONE, TIMEOUT and both counters.
REQ-029 SHALL treat RESTART in HOLD as restarting the hold count from 0.
REQ-030 SHALL treat RESTART in RUN or DRAIN as an abort, with CPU_RST_bar low on the following edge.
REQ-031 SHALL give RESTART priority over every other transition on the same edge.

Reset
REQ-032 SHALL, while RST_bar==0, asynchronously force state HOLD and set CPU_RST_bar=0, RUNNING=0, DONE=0, TIMEOUT=0, CYCLES=0, halt_q=0 and both counters to 0.
REQ-033 SHALL begin HOLD counting on the first rising edge after RST_bar rises.
REQ-034 SHALL, on RST_bar assertion mid-RUN or DRAIN, discard all progress and lower CPU_RST_bar without waiting for a clock edge.

Verification
REQ-035 SHALL verify nominal run: defaults; HALT rises 20 cycles after CPU_RST_bar rises -> CYCLES=20, DONE rises 5 edges later, RUNNING falls with it, TIMEOUT=0.
REQ-036 SHALL verify reset hold: release RST_bar -> CPU_RST_bar low for exactly 10 edges, then high; RUNNING rises on the same edge.
REQ-037 SHALL verify timeout: TIMEOUT_CYCLES=50, HALT held 0 -> TIMEOUT=1, CPU_RST_bar=0, CYCLES=50, DONE=0.
REQ-038 SHALL verify the tie: TIMEOUT_CYCLES=50 with HALT rising on the edge where CYCLES==50 -> DONE path taken, TIMEOUT stays 0.
REQ-039 SHALL verify immediate halt: HALT held 1 throughout HOLD -> rise detected on the first RUN edge, CYCLES=0, DONE after 5 edges.
REQ-040 SHALL verify restart: RESTART pulsed in FINISHED, then mid-RUN, then RST_bar pulsed mid-DRAIN -> each returns to HOLD with CYCLES=0, DONE=0, and a fresh 10-cycle CPU_RST_bar low.
